// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding,
// RISC-V load/store funct3 codes and the datapath width.
package lsu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MERGE = 3'd2,
    STORE = 3'd3,
    RESP  = 3'd4
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake with the CPU datapath plus the word-wide
// data memory port. The LSU uses the slave view; the CPU/memory side
// uses the master view.
interface lsu_if #(parameter int XLEN = lsu_pkg::XLEN);

  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_fault;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_din;
  logic            mem_read;
  logic            mem_write;
  logic [XLEN-1:0] mem_dout;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_dout,
    output req_ready, resp_valid, resp_rdata, resp_fault,
           mem_addr, mem_din, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_dout,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
           mem_addr, mem_din, mem_read, mem_write
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: extracts and extends load data from a
// memory word, merges sub-word store data into a word, and classifies
// the access as misaligned and/or carrying an illegal funct3.
module lsu_align
  import lsu_pkg::*;
(
  input  logic            is_write,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] word,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] store_word,
  output logic            misaligned,
  output logic            illegal
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  // Select the addressed byte and halfword lanes of the memory word
  always_comb begin
    byte_s = word[7:0];
    case (addr_lo)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      default: byte_s = word[31:24];
    endcase
    half_s = addr_lo[1] ? word[31:16] : word[15:0];
  end

  // Sign- or zero-extend the selected lane according to funct3
  always_comb begin
    load_data = word;
    case (funct3)
      F3_B:    load_data = {{(XLEN-8){byte_s[7]}}, byte_s};
      F3_H:    load_data = {{(XLEN-16){half_s[15]}}, half_s};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, byte_s};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, half_s};
      default: load_data = word;
    endcase
  end

  // Overlay store data onto the word read back from memory
  always_comb begin
    store_word = wdata;
    case (funct3[1:0])
      2'b00: begin
        store_word = word;
        case (addr_lo)
          2'd0:    store_word[7:0]   = wdata[7:0];
          2'd1:    store_word[15:8]  = wdata[7:0];
          2'd2:    store_word[23:16] = wdata[7:0];
          default: store_word[31:24] = wdata[7:0];
        endcase
      end
      2'b01:   store_word = addr_lo[1] ? {wdata[15:0], word[15:0]}
                                       : {word[31:16], wdata[15:0]};
      default: store_word = wdata;
    endcase
  end

  // Classify the access; 011 and the unsigned store encodings do not exist
  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = |addr_lo;
      default: misaligned = 1'b0;
    endcase
    if (is_write)
      illegal = funct3[2] || (funct3[1:0] == 2'b11);
    else
      illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU load/store per handshake, performs
// byte/halfword/word accesses on a word-only data memory (sub-word stores
// as read-modify-write) and returns extended load data or a fault flag.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  lsu_if.slave bus
);

  lsu_state_e      state_q, state_d;
  logic            write_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic            fault_q;

  logic            idle;
  logic            handshake;
  logic            al_write;
  logic [2:0]      al_funct3;
  logic [1:0]      al_addr;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] store_word;
  logic            misaligned;
  logic            illegal;
  logic            fault_now;
  logic [XLEN-1:0] word_addr;

  assign idle      = (state_q == IDLE);
  assign handshake = idle && bus.req_valid;
  assign fault_now = misaligned || illegal;
  assign word_addr = {addr_q[XLEN-1:2], 2'b00};

  // Alignment logic sees the live request while idle, the captured one after
  always_comb begin
    al_write  = write_q;
    al_funct3 = funct3_q;
    al_addr   = addr_q[1:0];
    al_wdata  = wdata_q;
    if (idle) begin
      al_write  = bus.req_write;
      al_funct3 = bus.req_funct3;
      al_addr   = bus.req_addr[1:0];
      al_wdata  = bus.req_wdata;
    end
  end

  lsu_align u_align (
    .is_write   (al_write),
    .funct3     (al_funct3),
    .addr_lo    (al_addr),
    .word       (bus.mem_dout),
    .wdata      (al_wdata),
    .load_data  (load_data),
    .store_word (store_word),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

  // Next-state selection: faults skip memory, SW skips the read phase
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (fault_now)                      state_d = RESP;
          else if (!bus.req_write)            state_d = LOAD;
          else if (bus.req_funct3[1:0] == 2'b10) state_d = STORE;
          else                                state_d = MERGE;
        end
      end
      LOAD:    state_d = RESP;
      MERGE:   state_d = STORE;
      STORE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decoded from state; write and response are squashed in reset
  always_comb begin
    bus.req_ready  = idle;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_din    = '0;
    bus.resp_valid = 1'b0;
    case (state_q)
      LOAD, MERGE: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = word_addr;
      end
      STORE: begin
        bus.mem_write = reset;
        bus.mem_addr  = word_addr;
        bus.mem_din   = wdata_q;
      end
      RESP:    bus.resp_valid = reset;
      default: ;
    endcase
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_fault = fault_q;

  // Control state and response registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        rdata_q <= '0;
        fault_q <= fault_now;
      end else if (state_q == LOAD) begin
        rdata_q <= load_data;
      end
    end
  end

  // Request capture; MERGE replaces the store data with the merged word
  always_ff @(posedge clk) begin
    if (handshake) begin
      write_q  <= bus.req_write;
      funct3_q <= bus.req_funct3;
      addr_q   <= bus.req_addr;
      wdata_q  <= bus.req_wdata;
    end else if (state_q == MERGE) begin
      wdata_q  <= store_word;
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Requester-side companion to the data memory: sits between the CPU datapath and the word-wide data memory. It accepts one load/store per handshake, performs RISC-V byte/halfword/word accesses on the word-only memory, and returns sign/zero-extended load data. Sub-word stores are done as read-modify-write, and misaligned or illegal accesses are flagged. Memory read is asynchronous; memory write commits on the rising clock edge.

## Interface
- XLEN, 32, data and address width; fixed at 32 for this design.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low; 0 at a rising edge resets the block.
- req_valid  in  1  CPU request present.
- req_ready  out  1  block can accept; equals (state == IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/half is used for SB/SH.
- resp_valid  out  1  one-cycle pulse marking completion.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  misaligned or illegal funct3; valid with resp_valid.
- mem_addr  out  32  {addr[31:2], 2'b00}; 0 when idle.
- mem_din  out  32  write word.
- mem_read  out  1  read enable.
- mem_write  out  1  write enable; forced 0 while reset is low.
- mem_dout  in  32  word at mem_addr, combinational.

## Operation
- States:
  - IDLE: request handshake happens when req_valid && req_ready. Capture write, funct3, addr and wdata.
  - LOAD: mem_read=1. Extract and extend at the edge into the rdata register, then go to RESP.
  - MERGE: mem_read=1. Replace the addressed byte/half of mem_dout with wdata at the edge, then go to STORE.
  - STORE: mem_write=1, mem_din = merged word (SB/SH) or wdata (SW), then go to RESP.
  - RESP: resp_valid=1, then go to IDLE.
- Transitions from IDLE on handshake:
  - fault → RESP with fault=1; no memory access.
  - load → LOAD.
  - SW → STORE.
  - SB/SH → MERGE.
- Misaligned accesses:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]≠0.
- Illegal funct3:
  - loads: 011, 110, 111.
  - stores: funct3[2]=1 or 011.
- Load extraction:
  - byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Merge rules:
  - SB writes wdata[7:0] into lane addr[1:0].
  - SH writes wdata[15:0] into half addr[1].
  - Other lanes keep the values read in MERGE.
- resp_rdata, resp_fault: registered, held until the next handshake.

## Timing
- Handshake occurs in cycle N (IDLE). Response cycles:
  - fault: resp_valid in N+1.
  - load or SW: resp_valid in N+2.
  - SB/SH: MERGE in N+1, STORE in N+2, resp_valid in N+3.
- req_ready=0 from N+1 until the cycle after RESP; a new request is accepted no earlier than the cycle after resp_valid.
- A request held valid while busy is accepted on return to IDLE; no request is lost or duplicated.
- Memory writes commit only at the rising edge that ends the STORE cycle.
- Reset:
  - After reset: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_read=0, mem_write=0, mem_addr=0, mem_din=0.
  - Reset low in any state aborts the access. No write occurs, including from STORE in the reset cycle, and no resp_valid is produced.
- Only one request is in flight at a time; there is no response backpressure.

## Structure
- Package lsu_pkg holds:
  - state encoding (IDLE, LOAD, MERGE, STORE, RESP);
  - funct3 constants;
  - the XLEN default.
- Sub-module lsu_align (purely combinational):
  - inputs: funct3, addr[1:0], word, wdata.
  - outputs: extended load data, merged store word, misaligned flag, illegal flag.
- Top level is the FSM plus capture registers. Expected size is about 200 lines.

## Test plan
- Memory word 0x100 = 0x8040_20F1.
  - LB 0x103 → resp_rdata 0xFFFF_FF80 at N+2, fault 0.
  - LBU 0x103 → 0x0000_0080.
  - LHU 0x102 → 0x0000_8040.
- SB 0x101 with wdata 0x0000_00AA:
  - mem_read=1 at N+1; mem_write=1 with mem_din 0x8040_AAF1 at N+2; resp at N+3.
  - Follow-up LW 0x100 → 0x8040_AAF1.
- Faults:
  - LW 0x102 → resp_fault=1 at N+1, rdata 0, no mem_read or mem_write.
  - SH 0x101 → same.
  - funct3 110 load → same.
- Back-to-back: req_valid held high for two SWs (0x200, 0x204).
  - req_ready low while busy.
  - Exactly two mem_write pulses and two resp_valid pulses.
- Reset low during MERGE, and separately during STORE:
  - no mem_write; memory word unchanged; next cycle IDLE with req_ready=1 and all outputs at their reset values.
